// File: rtl/ttm4_exec_sequencer.sv
// ttm4_exec_sequencer
//   Instruction sequencer for the TTM4 emulator core. It owns the PC and the
//   IR, fetches through a REQ/ACK handshake, holds the fields for the decoder
//   for one DECODE cycle, opens a single EXEC cycle for the decoder strobes and
//   commits the next PC in UPDATE. Supports run/stop/single-step control.
//
//   Optional feature macro: TTM4_BREAKPOINT_EN (PC breakpoint on i_brk_addr).
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start/i_stop/i_step    one-cycle control pulses
//   o_imem_req, o_imem_addr  fetch request (held until ACK) and address (= PC)
//   i_imem_ack, i_imem_data  fetch data valid and instruction {OP,SR,LR}
//   o_op, o_sr, o_lr         IR fields to the decoder
//   i_pc_nld, i_jmp_addr     decoder jump decision (0 = taken) and target
//   o_exec_en, o_flag_ld     decoder strobe enable / flag capture (EXEC only)
//   o_pc                     program counter
//   o_running, o_step_done   not-halted status, end-of-step pulse
//   i_brk_addr, o_brk_hit    breakpoint address, sticky breakpoint halt
//   o_fault                  sticky fetch ACK timeout
//
// state  | meaning
// HALT   | idle, waiting for START or STEP
// FETCH  | IMEM_REQ high, waiting for ACK (bounded by ACK_TIMEOUT)
// DECODE | decoder settles on the new IR
// EXEC   | decoder strobes enabled, jump decision registered
// UPDATE | PC committed, choose HALT or next FETCH
module ttm4_exec_sequencer #(
  parameter int PC_W        = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic            i_step,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [10:0]     i_imem_data,
  output logic [4:0]      o_op,
  output logic [2:0]      o_sr,
  output logic [2:0]      o_lr,
  input  logic            i_pc_nld,
  input  logic [PC_W-1:0] i_jmp_addr,
  output logic            o_exec_en,
  output logic            o_flag_ld,
  output logic [PC_W-1:0] o_pc,
  output logic            o_running,
  output logic            o_step_done,
  input  logic [PC_W-1:0] i_brk_addr,
  output logic            o_brk_hit,
  output logic            o_fault
);

  typedef enum logic [2:0] {
    S_HALT, S_FETCH, S_DECODE, S_EXEC, S_UPDATE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, r_jmp_addr, w_pc_nxt;
  logic [10:0]     r_ir;
  logic [7:0]      r_wait_cnt;
  logic            r_pc_nld, r_stop_pend, r_step_mode;
  logic            r_step_done, r_brk_hit, r_fault;
  logic            w_start_ok, w_step_ok, w_go, w_brk_match, w_end;

  // STOP beats START, START beats STEP when they coincide in HALT.
  assign w_start_ok = (r_state == S_HALT) && i_start && !i_stop;
  assign w_step_ok  = (r_state == S_HALT) && i_step && !i_start && !i_stop;
  assign w_go       = w_start_ok || w_step_ok;

  assign w_pc_nxt = r_pc_nld ? (r_pc + PC_W'(1)) : r_jmp_addr;

`ifdef TTM4_BREAKPOINT_EN
  // Checked on the next PC only, so a resumed START always executes the
  // instruction sitting at the breakpoint before it can trip again.
  assign w_brk_match = !r_step_mode && (w_pc_nxt == i_brk_addr);
`else
  logic w_unused_brk;
  assign w_unused_brk = ^i_brk_addr;
  assign w_brk_match  = 1'b0;
`endif

  // A STOP arriving in UPDATE itself still ends this instruction.
  assign w_end = r_step_mode || r_stop_pend || i_stop || w_brk_match;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_HALT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HALT:   if (w_go) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (i_imem_ack)            w_state_nxt = S_DECODE;
        else if (r_wait_cnt == '0) w_state_nxt = S_HALT;
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC:   w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = w_end ? S_HALT : S_FETCH;
      default:  w_state_nxt = S_HALT;
    endcase
  end

  always_comb begin
    o_imem_req = 1'b0;
    o_exec_en  = 1'b0;
    o_flag_ld  = 1'b0;
    o_running  = 1'b1;
    case (r_state)
      S_HALT:  o_running  = 1'b0;
      S_FETCH: o_imem_req = 1'b1;
      S_EXEC: begin
        o_exec_en = 1'b1;
        o_flag_ld = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_jmp_addr  <= '0;
      r_pc_nld    <= 1'b1;
      r_wait_cnt  <= 8'(ACK_TIMEOUT - 1);
      r_stop_pend <= 1'b0;
      r_step_mode <= 1'b0;
      r_step_done <= 1'b0;
      r_brk_hit   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_step_done <= (r_state == S_UPDATE) && r_step_mode;

      if (w_go) begin
        r_step_mode <= w_step_ok;
        r_brk_hit   <= 1'b0;
        r_fault     <= 1'b0;
      end

      if (r_state != S_HALT) begin
        if (w_state_nxt == S_HALT) r_stop_pend <= 1'b0;
        else if (i_stop)           r_stop_pend <= 1'b1;
      end

      // Terminal count reached in FETCH means ACK_TIMEOUT cycles without ACK.
      if (r_state != S_FETCH)      r_wait_cnt <= 8'(ACK_TIMEOUT - 1);
      else if (r_wait_cnt != '0)   r_wait_cnt <= r_wait_cnt - 8'd1;

      if (r_state == S_FETCH) begin
        if (i_imem_ack)            r_ir    <= i_imem_data;
        else if (r_wait_cnt == '0) r_fault <= 1'b1;
      end

      if (r_state == S_EXEC) begin
        r_pc_nld   <= i_pc_nld;
        r_jmp_addr <= i_jmp_addr;
      end

      if (r_state == S_UPDATE) begin
        r_pc <= w_pc_nxt;
        if (w_brk_match) r_brk_hit <= 1'b1;
      end
    end
  end

  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_op        = r_ir[10:6];
  assign o_sr        = r_ir[5:3];
  assign o_lr        = r_ir[2:0];
  assign o_step_done = r_step_done;
  assign o_brk_hit   = r_brk_hit;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_ttm4_exec_sequencer.sv
// Testbench for ttm4_exec_sequencer. Expected {IR, next PC} pairs are pushed
// when an instruction is served and popped when the DUT pulses EXEC_EN.
module tb_ttm4_exec_sequencer;

  logic       clk = 1'b0;
  logic       i_rst, i_start, i_stop, i_step;
  logic       o_imem_req;
  logic [7:0] o_imem_addr;
  logic       i_imem_ack;
  logic [10:0] i_imem_data;
  logic [4:0] o_op;
  logic [2:0] o_sr, o_lr;
  logic       i_pc_nld;
  logic [7:0] i_jmp_addr;
  logic       o_exec_en, o_flag_ld;
  logic [7:0] o_pc;
  logic       o_running, o_step_done;
  logic [7:0] i_brk_addr;
  logic       o_brk_hit, o_fault;

  always #10 clk = ~clk;

  ttm4_exec_sequencer #(.PC_W(8), .ACK_TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_step(i_step), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data), .o_op(o_op),
    .o_sr(o_sr), .o_lr(o_lr), .i_pc_nld(i_pc_nld), .i_jmp_addr(i_jmp_addr),
    .o_exec_en(o_exec_en), .o_flag_ld(o_flag_ld), .o_pc(o_pc),
    .o_running(o_running), .o_step_done(o_step_done),
    .i_brk_addr(i_brk_addr), .o_brk_hit(o_brk_hit), .o_fault(o_fault)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  logic [18:0] sb_q[$];
  int          exec_cyc[$];
  int          pend = 0;
  logic [7:0]  pend_pc;
  logic [18:0] sb_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // EXEC monitor: fields at EXEC, one-cycle width, PC two negedges later.
  always @(negedge clk) begin
    if (pend == 2) begin
      chk("exec_width", o_exec_en, 0);
      pend = 1;
    end else if (pend == 1) begin
      chk("pc_after_update", o_pc, pend_pc);
      chk("imem_addr_eq_pc", o_imem_addr, pend_pc);
      pend = 0;
    end else if (o_exec_en) begin
      exec_cyc.push_back(cyc);
      chk("flag_ld_in_exec", o_flag_ld, 1);
      chk("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        chk("ir_fields", {o_op, o_sr, o_lr}, sb_e[18:8]);
        pend_pc = sb_e[7:0];
        pend = 2;
      end
    end
  end

  task automatic serve(input int dly, input logic [10:0] data, input logic nld,
                       input logic [7:0] jaddr, input logic [7:0] exp_pc,
                       input bit stop_in_exec);
    int n = 0;
    while (!o_imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", o_imem_req, 1);
    repeat (dly) @(negedge clk);
    i_imem_ack  = 1'b1;
    i_imem_data = data;
    i_pc_nld    = nld;
    i_jmp_addr  = jaddr;
    sb_q.push_back({data, exp_pc});
    @(negedge clk);
    i_imem_ack = 1'b0;
    @(negedge clk);
    if (stop_in_exec) i_stop = 1'b1;
    @(negedge clk);
    i_stop     = 1'b0;
    i_pc_nld   = 1'b1;
    i_jmp_addr = '0;
  endtask

  task automatic wait_halt();
    int n = 0;
    while (o_running && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", o_running, 0);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic pulse_step();
    i_step = 1'b1;
    @(negedge clk);
    i_step = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0, n;
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_step = 1'b0;
    i_imem_ack = 1'b0; i_imem_data = '0; i_pc_nld = 1'b1;
    i_jmp_addr = '0; i_brk_addr = 8'h03;
    do_reset();

    chk("rst_req", o_imem_req, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_addr", o_imem_addr, 0);
    chk("rst_fields", {o_op, o_sr, o_lr}, 0);
    chk("rst_exec", {o_exec_en, o_flag_ld}, 0);
    chk("rst_status", {o_running, o_step_done, o_brk_hit, o_fault}, 0);

    // reset while a fetch is outstanding; the late ACK must be ignored
    pulse_start();
    chk("midfetch_req", o_imem_req, 1);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    i_imem_ack = 1'b1;
    i_imem_data = 11'h7FF;
    @(negedge clk);
    i_imem_ack = 1'b0;
    chk("midfetch_rst_req", o_imem_req, 0);
    chk("midfetch_rst_pc", o_pc, 0);
    chk("midfetch_rst_run", o_running, 0);
    chk("midfetch_rst_ir", {o_op, o_sr, o_lr}, 0);

    // single step, zero-wait ACK
    pulse_step();
    c0 = cyc;
    serve(0, {5'b00001, 3'b001, 3'b010}, 1'b1, 8'h00, 8'h01, 1'b0);
    @(negedge clk);
    chk("step_halt", o_running, 0);
    chk("step_done", o_step_done, 1);
    chk("step_cycles", cyc - c0, 4);
    @(negedge clk);
    chk("step_done_pulse", o_step_done, 0);

    // run mode, 3 wait cycles per fetch, STOP in EXEC of the 3rd
    do_reset();
    exec_cyc.delete();
    pulse_start();
    serve(3, 11'h0A5, 1'b1, 8'h00, 8'h01, 1'b0);
    serve(3, 11'h35A, 1'b1, 8'h00, 8'h02, 1'b0);
    serve(3, 11'h1C3, 1'b1, 8'h00, 8'h03, 1'b1);
    wait_halt();
    chk("run_stop_pc", o_pc, 8'h03);
    chk("run_exec_count", exec_cyc.size(), 3);
    if (exec_cyc.size() == 3) begin
      chk("run_period_1", exec_cyc[1] - exec_cyc[0], 7);
      chk("run_period_2", exec_cyc[2] - exec_cyc[1], 7);
    end

    // START with STOP in HALT stays halted
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_stop  = 1'b0;
    chk("start_stop_halt", o_running, 0);

    // jump taken, then wrap from 0xFF
    pulse_step();
    serve(0, 11'h2AA, 1'b0, 8'h40, 8'h40, 1'b0);
    wait_halt();
    chk("jump_pc", o_pc, 8'h40);
    pulse_step();
    serve(1, 11'h155, 1'b0, 8'hFF, 8'hFF, 1'b0);
    wait_halt();
    pulse_step();
    serve(0, 11'h0F0, 1'b1, 8'h00, 8'h00, 1'b0);
    wait_halt();
    chk("pc_wrap", o_pc, 8'h00);

    // ACK timeout
    pulse_start();
    n = 0;
    while (o_imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_cycles", n, 15);
    chk("fault_set", o_fault, 1);
    chk("fault_halt", o_running, 0);
    chk("fault_pc", o_pc, 8'h00);
    pulse_start();
    chk("fault_cleared", o_fault, 0);
    serve(0, 11'h3C3, 1'b1, 8'h00, 8'h01, 1'b1);
    wait_halt();
    chk("after_fault_pc", o_pc, 8'h01);

    // breakpoint at 0x03
    do_reset();
    i_brk_addr = 8'h03;
    pulse_start();
    serve(0, 11'h011, 1'b1, 8'h00, 8'h01, 1'b0);
    serve(2, 11'h022, 1'b1, 8'h00, 8'h02, 1'b0);
    serve(0, 11'h033, 1'b1, 8'h00, 8'h03, 1'b0);
    @(negedge clk);
`ifdef TTM4_BREAKPOINT_EN
    chk("brk_halt", o_running, 0);
    chk("brk_pc", o_pc, 8'h03);
    chk("brk_hit", o_brk_hit, 1);
    pulse_start();
    chk("brk_cleared", o_brk_hit, 0);
    chk("brk_resume_addr", o_imem_addr, 8'h03);
`else
    chk("nobrk_running", o_running, 1);
    chk("nobrk_hit", o_brk_hit, 0);
`endif
    serve(0, 11'h044, 1'b1, 8'h00, 8'h04, 1'b1);
    wait_halt();
    chk("brk_final_pc", o_pc, 8'h04);
    chk("brk_final_hit", o_brk_hit, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
